ps2_key_event_decoder: RTL and testbench

- Sits directly downstream of the PS/2 receiver FIFO.
- Pops scan-code bytes using the FIFO's ready/nextdata_n handshake and assembles the set-2 prefixes (E0 extended, F0 break) into single key events.
- Tracks the currently held key, suppresses typematic repeats from the press count, and exposes a sticky error when the FIFO overflows.
- Its outputs feed the ASCII conversion, counter and seven-segment display stages.

---
 rtl/ps2_pkg.sv | 26 ++
 rtl/ps2_prefix_tracker.sv | 34 +++
 rtl/ps2_key_event_decoder.sv | 116 +++++++++++
 tb/tb_ps2_key_event_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM state encoding and byte classification
// for the PS/2 key event decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POP  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // Keyboard housekeeping replies that never belong to a key event.
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
           (b == SC_ECHO) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_prefix_tracker.sv
// Accumulates the E0/F0 prefixes of a set-2 scan sequence and flags the
// byte that completes a key event.
module ps2_prefix_tracker
  import ps2_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       decode,
  input  logic [7:0] code,
  output logic       ext_pend,
  output logic       brk_pend,
  output logic       code_done
);

  assign code_done = decode && (code != SC_EXT) && (code != SC_BRK) && !is_ignored(code);

  // Prefixes stack in any order; any non-prefix byte consumes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (decode) begin
      if (code == SC_EXT) begin
        ext_pend <= 1'b1;
      end else if (code == SC_BRK) begin
        brk_pend <= 1'b1;
      end else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_event_decoder.sv
// Pops scan-code bytes from the PS/2 receive FIFO and turns them into key
// events with held-key tracking, a press counter and a sticky overflow flag.
module ps2_key_event_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int COUNT_REPEAT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_ready,
  input  logic             fifo_overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic             held,
  output logic [7:0]       held_code,
  output logic             held_ext,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [7:0] byte_q;
  logic       ext_pend;
  logic       brk_pend;
  logic       code_done;
  logic       same_key;

  ps2_prefix_tracker u_prefix (
    .clk       (clk),
    .rst       (rst),
    .decode    (state == S_POP),
    .code      (byte_q),
    .ext_pend  (ext_pend),
    .brk_pend  (brk_pend),
    .code_done (code_done)
  );

  assign same_key = held && (held_ext == ext_pend) && (held_code == byte_q);

  // Pop handshake, event decode and held-key bookkeeping in one place so
  // every output is registered and changes on the S_POP -> S_WAIT edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_q      <= 8'h00;
      nextdata_n  <= 1'b1;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      held        <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      press_count <= '0;
      err         <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (fifo_overflow) begin
        err <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          nextdata_n <= 1'b1;
          if (fifo_ready) begin
            byte_q     <= fifo_data;
            nextdata_n <= 1'b0;
            state      <= S_POP;
          end
        end
        S_POP: begin
          nextdata_n <= 1'b1;
          state      <= S_WAIT;
          if (code_done) begin
            key_valid   <= 1'b1;
            key_code    <= byte_q;
            key_ext     <= ext_pend;
            key_release <= brk_pend;
            key_repeat  <= !brk_pend && same_key;
            if (!brk_pend) begin
              if (same_key) begin
                if (COUNT_REPEAT != 0) begin
                  press_count <= press_count + CNT_ONE;
                end
              end else begin
                held        <= 1'b1;
                held_code   <= byte_q;
                held_ext    <= ext_pend;
                press_count <= press_count + CNT_ONE;
              end
            end else if (same_key) begin
              held <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          nextdata_n <= 1'b1;
          state      <= S_IDLE;
        end
        default: begin
          nextdata_n <= 1'b1;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Self-checking bench: a queue-based FIFO feeds the decoder and a
// scan-code level reference model predicts every key event.
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] fifo_data = 8'h00;
  logic       fifo_ready = 1'b0;
  logic       fifo_overflow = 1'b0;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_repeat;
  logic       held;
  logic [7:0] held_code;
  logic       held_ext;
  logic [7:0] press_count;
  logic       err;

  ps2_key_event_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_data     (fifo_data),
    .fifo_ready    (fifo_ready),
    .fifo_overflow (fifo_overflow),
    .nextdata_n    (nextdata_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .key_ext       (key_ext),
    .key_release   (key_release),
    .key_repeat    (key_repeat),
    .held          (held),
    .held_code     (held_code),
    .held_ext      (held_ext),
    .press_count   (press_count),
    .err           (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic       held;
    logic [7:0] held_code;
    logic       held_ext;
    logic [7:0] count;
  } event_t;

  int total = 0;
  int bad = 0;
  int pushed = 0;
  int popped = 0;
  int pulses = 0;
  logic prev_low = 1'b0;

  logic [7:0] fifo_q[$];
  event_t     exp_q[$];

  logic       m_ext, m_brk, m_held, m_hext;
  logic [7:0] m_hcode, m_count;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic modelReset();
    m_ext = 0; m_brk = 0; m_held = 0; m_hext = 0; m_hcode = 8'h00; m_count = 8'h00;
  endtask

  // Reference model works on whole scan-code sequences, not FSM cycles.
  task automatic modelByte(input logic [7:0] b);
    event_t e;
    logic same;
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
    end else begin
      same = m_held && (m_hext == m_ext) && (m_hcode == b);
      e.code = b; e.ext = m_ext; e.rel = m_brk; e.rep = !m_brk && same;
      if (!m_brk) begin
        if (!same) begin
          m_held = 1; m_hcode = b; m_hext = m_ext; m_count = m_count + 8'd1;
        end
      end else if (same) m_held = 0;
      e.held = m_held; e.held_code = m_hcode; e.held_ext = m_hext; e.count = m_count;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    fifo_q.push_back(b);
    pushed++;
    modelByte(b);
  endtask

  task automatic drain();
    int idle = 0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (fifo_q.size() == 0) idle++; else idle = 0;
      if (idle >= 5) return;
    end
    checkOutput("drain_timeout", 1, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    modelReset();
  endtask

  // FIFO model: pop on the edge that ends the low nextdata_n cycle.
  always @(posedge clk) begin
    if (nextdata_n == 1'b0 && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      popped++;
    end
    #1;
    fifo_ready = (fifo_q.size() != 0);
    fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (nextdata_n == 1'b0) begin
        pulses++;
        if (prev_low) checkOutput("nextdata_n_width", 2, 1);
      end
      prev_low = (nextdata_n == 1'b0);
      if (key_valid) begin
        if (exp_q.size() == 0) checkOutput("unexpected_event", {24'h0, key_code}, 32'h0);
        else begin
          event_t e;
          e = exp_q.pop_front();
          checkOutput("key_code", key_code, e.code);
          checkOutput("key_flags", {key_ext, key_release, key_repeat}, {e.ext, e.rel, e.rep});
          checkOutput("held", {held, held_ext, held_code}, {e.held, e.held_ext, e.held_code});
          checkOutput("press_count", press_count, e.count);
        end
      end
    end else prev_low = 1'b0;
  end

  initial begin
    logic [7:0] b;
    logic [7:0] keys[3];
    keys[0] = 8'h1C; keys[1] = 8'h32; keys[2] = 8'h75;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", {nextdata_n, key_valid, held, press_count, err}, {1'b1, 1'b0, 1'b0, 8'h00, 1'b0});
    rst = 0;

    applyStimulus(8'h1C);
    drain();
    checkOutput("single_pulses", pulses, 1);
    checkOutput("single_held", {held, held_code, press_count}, {1'b1, 8'h1C, 8'd1});

    doReset();
    foreach (keys[i]) begin end
    applyStimulus(8'h1C); applyStimulus(8'h1C); applyStimulus(8'h1C);
    applyStimulus(8'hF0); applyStimulus(8'h1C);
    drain();
    checkOutput("repeat_count", {held, press_count}, {1'b0, 8'd1});

    applyStimulus(8'hE0); applyStimulus(8'h75);
    applyStimulus(8'hE0); applyStimulus(8'hF0); applyStimulus(8'h75);
    drain();
    checkOutput("ext_break_held", held, 1'b0);

    doReset();
    applyStimulus(8'h1C); applyStimulus(8'h32); applyStimulus(8'hF0); applyStimulus(8'h1C);
    drain();
    checkOutput("other_break", {held, held_code, press_count}, {1'b1, 8'h32, 8'd2});

    applyStimulus(8'hF0); applyStimulus(8'hAA); applyStimulus(8'h1C);
    applyStimulus(8'hFA);
    drain();
    checkOutput("prefix_cleared", {held, held_code, key_release}, {1'b1, 8'h1C, 1'b0});

    for (int i = 0; i < 400 && m_count != 8'hFF; i++) begin
      b = 8'h01 + 8'(i % 112);
      applyStimulus(b); applyStimulus(8'hF0); applyStimulus(b);
      if (fifo_q.size() > 30) drain();
    end
    drain();
    checkOutput("count_255", press_count, 8'hFF);
    applyStimulus(8'h7A);
    drain();
    checkOutput("count_wrap", press_count, 8'h00);

    @(negedge clk); fifo_overflow = 1;
    @(negedge clk); fifo_overflow = 0;
    checkOutput("err_set", err, 1'b1);
    applyStimulus(8'h32);
    drain();
    checkOutput("err_sticky", err, 1'b1);

    applyStimulus(8'hE0);
    drain();
    doReset();
    checkOutput("err_cleared", {err, held, press_count}, {1'b0, 1'b0, 8'h00});
    applyStimulus(8'h75);
    drain();
    checkOutput("post_reset_ext", {key_code, key_ext}, {8'h75, 1'b0});

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hAA;
        3: b = 8'hFA;
        4, 5, 6: b = keys[$urandom_range(0, 2)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      applyStimulus(b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
      if (fifo_q.size() > 20) drain();
    end
    drain();

    checkOutput("missing_events", exp_q.size(), 0);
    checkOutput("pop_count", popped, pushed);
    checkOutput("pulse_count", pulses, pushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
